// File: rtl/uart_pkg.sv
// Shared UART types and framing constants for the receive path
// (and later the transmit path).
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    localparam int         OVERSAMPLE  = 16;
    localparam logic [3:0] MID_SAMPLE  = 4'd7;
    localparam logic [3:0] LAST_SAMPLE = 4'd15;
    localparam int         DATA_BITS   = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: head word is always on rd_data, zero when empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= push_data;
    end

    assign rd_data = empty ? '0 : mem[rptr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with 16x oversampling, show-ahead receive FIFO and
// sticky overrun / framing-error flags for the CPU status register.
module uart_rx_fifo import uart_pkg::*; #(
    parameter int DIV        = 325,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       UART_RX,
    input  logic       rd_en,
    input  logic       err_clr,
    output logic [7:0] rd_data,
    output logic       rx_valid,
    output logic       fifo_full,
    output logic       overrun,
    output logic       frame_err
);

    localparam int            TW       = $clog2(DIV);
    localparam logic [TW-1:0] TICK_MAX = TW'(DIV - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

    logic                            sync_p0;
    logic                            rx_s;
    logic [TW-1:0]                   tcnt;
    logic                            tick;
    logic                            tick_rst;
    state_t                          state, state_n;
    logic [$clog2(OVERSAMPLE)-1:0]   scnt, scnt_n;
    logic [2:0]                      bcnt, bcnt_n;
    logic [DATA_BITS-1:0]            shreg, shreg_n;
    logic                            push;
    logic                            ferr_set;
    logic                            ovr_set;
    logic                            fifo_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            sync_p0 <= UART_RX;
            rx_s    <= sync_p0;
        end
    end

    // Free-running tick; restarted on the start edge so sampling is bit-centred.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                tcnt <= '0;
        else if (tick_rst | tick) tcnt <= '0;
        else                      tcnt <= tcnt + 1'b1;
    end

    assign tick = (tcnt == TICK_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            scnt  <= '0;
            bcnt  <= '0;
        end else begin
            state <= state_n;
            scnt  <= scnt_n;
            bcnt  <= bcnt_n;
        end
    end

    always_ff @(posedge clk) begin
        shreg <= shreg_n;
    end

    always_comb begin
        state_n  = state;
        scnt_n   = scnt;
        bcnt_n   = bcnt;
        shreg_n  = shreg;
        push     = 1'b0;
        ferr_set = 1'b0;
        tick_rst = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n  = START;
                    scnt_n   = '0;
                    tick_rst = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    if (scnt == MID_SAMPLE) begin
                        state_n = rx_s ? IDLE : DATA;
                        scnt_n  = '0;
                        bcnt_n  = '0;
                    end else begin
                        scnt_n = scnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (scnt == LAST_SAMPLE) begin
                        shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
                        scnt_n  = '0;
                        bcnt_n  = bcnt + 1'b1;
                        if (bcnt == LAST_BIT) state_n = STOP;
                    end else begin
                        scnt_n = scnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (scnt == LAST_SAMPLE) begin
                        push     = rx_s;
                        ferr_set = ~rx_s;
                        state_n  = rx_s ? IDLE : BRK;
                        scnt_n   = '0;
                    end else begin
                        scnt_n = scnt + 1'b1;
                    end
                end
            end
            BRK: begin
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // A simultaneous pop frees the slot, so only an unpopped full FIFO overruns.
    assign ovr_set = push & fifo_full & ~rd_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (ovr_set)      overrun <= 1'b1;
            else if (err_clr) overrun <= 1'b0;
            if (ferr_set)     frame_err <= 1'b1;
            else if (err_clr) frame_err <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (shreg_n),
        .pop       (rd_en),
        .rd_data   (rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rx_valid = ~fifo_empty;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Memory-mapped UART receive front-end that feeds the CPU_single peripheral bus.
- Takes the raw UART_RX pin, synchronises it, and oversamples 16x.
- Deframes 8N1 characters and buffers them in a small show-ahead FIFO that the CPU pops with a one-cycle read strobe.
- Reports sticky overrun and framing-error flags for the CPU status register.

Parameters:
- DIV, 325, system clocks per oversample tick (50 MHz / (9600 × 16), truncated); minimum legal value 2.
- FIFO_DEPTH, 4, number of buffered bytes; power of two, 2..16.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- UART_RX  input  1  raw serial line, idle high, asynchronous to clk
- rd_en  input  1  CPU pop strobe, one byte per asserted cycle
- rd_data  output  8  byte at FIFO head (show-ahead); 8'h00 when empty
- rx_valid  output  1  FIFO not empty
- fifo_full  output  1  FIFO holds FIFO_DEPTH bytes
- overrun  output  1  sticky: a completed byte was dropped because the FIFO was full
- frame_err  output  1  sticky: stop bit sampled low
- err_clr  input  1  clears overrun and frame_err

Behaviour:
- Reset (async, active-high):
  - Synchroniser flops are set to 1 and the FSM goes to IDLE.
  - Tick counter, sample counter, bit counter and FIFO pointers are zeroed.
  - All outputs are 0.
- Synchroniser: UART_RX passes through 2 flops to give rx_s. All sampling uses rx_s only.
- Tick generator:
  - A counter runs 0..DIV-1 and pulses tick for one cycle at DIV-1.
  - It free-runs in every state, including IDLE.
  - On the IDLE→START transition the counter is restarted at 0 so the bit phase aligns to the start edge.
- FSM states: IDLE, START, DATA, STOP, BRK.
  - IDLE: when rx_s==0 on any cycle → START, with sample count scnt = 0.
  - START:
    - scnt increments on each tick.
    - At the tick where scnt==7 (mid-bit): if rx_s==0 → DATA with scnt = 0 and bit count = 0.
    - Otherwise it is a glitch → IDLE, with nothing pushed and no flag set.
  - DATA:
    - At each tick where scnt==15, sample rx_s into the shift register LSB-first and reset scnt to 0.
    - After the 8th bit → STOP.
  - STOP, at the tick where scnt==15:
    - If rx_s==1: push the byte, then → IDLE.
    - If rx_s==0: set frame_err, discard the byte, then → BRK.
  - BRK: wait for rx_s==1, then → IDLE. This blocks retriggering during a line break.
- Push latency: the byte is visible on rd_data, and rx_valid is 1, on the cycle after the stop-sample tick.
- FIFO:
  - Push happens only from STOP with a good stop bit.
  - Full with no simultaneous pop: the byte is dropped and overrun is set.
  - Full with a simultaneous pop: both the pop and the push happen, occupancy is unchanged and overrun is not set.
  - rd_en while empty is ignored and the pointers do not move.
  - Pointers wrap modulo FIFO_DEPTH. The occupancy count is log2(FIFO_DEPTH)+1 bits wide.
- Error flags:
  - err_clr clears both flags the next cycle.
  - If a set event and err_clr occur in the same cycle, set wins.
- Reset asserted mid-frame: the partial byte is lost, the FIFO is emptied and the flags are cleared. After reset deassertion the first valid start edge is accepted.

Decomposition:
- Package uart_pkg:
  - State enum {IDLE, START, DATA, STOP, BRK}.
  - OVERSAMPLE=16, MID_SAMPLE=7, LAST_SAMPLE=15, DATA_BITS=8.
- Sub-module sync_fifo (parameters WIDTH=8, DEPTH=FIFO_DEPTH):
  - push/pop/full/empty interface with show-ahead output.
  - Reused later by the UART_TX path.

Test Plan (run with DIV=4):
- Send 8'hA5 at nominal baud → after the stop sample, rx_valid=1 and rd_data=8'hA5. Pulse rd_en → rx_valid=0 and rd_data=8'h00.
- Hold UART_RX low for 6 ticks, then high → FSM returns to IDLE, rx_valid stays 0 and frame_err stays 0.
- Send 5 bytes 8'h01..8'h05 with no reads → fifo_full=1, overrun=1, and pops return 8'h01..8'h04 in order.
- FIFO full while the 5th byte's stop sample coincides with rd_en → overrun stays 0 and the final contents are 8'h02..8'h05.
- Send 8'h3C with the stop bit low, holding the line low for 3 bit times → frame_err=1, nothing pushed, no retrigger until the line goes high. Next byte 8'h7E is received correctly.
- Assert reset during the 4th data bit of 8'hFF with 2 bytes queued → all outputs 0. After release, 8'h55 is received as the only FIFO entry.
